// File: rtl/int_sched_if.sv
// CPU-side bundle of the interrupt scheduler: boundary/return strobes in,
// PC-load override and data-bus drive out.
interface int_sched_if;
   logic       BOUNDARY;
   logic       IRET;
   logic [7:0] PC_IN;
   logic       TAKE;
   logic       LPC_OVR;
   logic       BUS_OE;
   logic [7:0] BUS_OUT;

   modport master (
      output BOUNDARY,
      output IRET,
      output PC_IN,
      input  TAKE,
      input  LPC_OVR,
      input  BUS_OE,
      input  BUS_OUT
   );

   modport slave (
      input  BOUNDARY,
      input  IRET,
      input  PC_IN,
      output TAKE,
      output LPC_OVR,
      output BUS_OE,
      output BUS_OUT
   );
endinterface

// File: rtl/int_sched.sv
// Four-source interrupt scheduler forcing a vector into PC for one T3 cycle.
// Define INT_EDGE_EN for edge-triggered pending bits (level-sensitive otherwise).
module int_sched #(
   parameter logic [7:0] VEC_BASE = 8'hF0
) (
   input  logic       T3,
   input  logic       CLR,
   input  logic [3:0] IRQ,
   input  logic       MASK_WE,
   input  logic [3:0] MASK_D,
   input  logic       EI,
   input  logic       DI,
   output logic [3:0] INT_ACK,
   output logic       IE,
   output logic [3:0] PEND,
   output logic       IN_SERVICE,
   int_sched_if.slave cpu
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ACK   = 2'd1;
   localparam logic [1:0] S_SERVE = 2'd2;
   localparam logic [1:0] S_RETN  = 2'd3;

   logic [1:0] state_q, state_d;
   logic [3:0] pend_q, pend_d;
   logic [3:0] mask_q, mask_d;
   logic       ie_q, ie_d;
   logic [7:0] ret_q, ret_d;
   logic [1:0] id_q, id_d;

   logic [3:0] elig;
   logic [1:0] sel;
   logic       accept;

   assign elig   = pend_q & ~mask_q;
   assign accept = (state_q == S_IDLE) & cpu.BOUNDARY
                 & ie_q & (|elig);

   // lowest index wins
   always_comb begin
      sel = 2'd0;
      if (elig[0])      sel = 2'd0;
      else if (elig[1]) sel = 2'd1;
      else if (elig[2]) sel = 2'd2;
      else if (elig[3]) sel = 2'd3;
   end

   always_comb begin
      state_d = state_q;
      ret_d   = ret_q;
      id_d    = id_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_ACK;
               ret_d   = cpu.PC_IN;
               id_d    = sel;
            end
         end
         S_ACK:   state_d = S_SERVE;
         S_SERVE: if (cpu.IRET) state_d = S_RETN;
         S_RETN:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // acceptance clear has the last word over EI
   always_comb begin
      ie_d = ie_q;
      if (state_q == S_RETN) ie_d = 1'b1;
      if (EI)                ie_d = 1'b1;
      if (DI)                ie_d = 1'b0;
      if (accept)            ie_d = 1'b0;
   end

   assign mask_d = MASK_WE ? MASK_D : mask_q;

`ifdef INT_EDGE_EN
   logic [3:0] irq_q;
   logic [3:0] rise;
   logic [3:0] ack_clr;

   assign rise    = IRQ & ~irq_q;
   assign ack_clr = accept ? (4'b0001 << sel) : 4'b0000;
   // a fresh edge outranks its own acknowledge clear
   assign pend_d  = (pend_q & ~ack_clr) | rise;

   always_ff @(negedge T3 or negedge CLR) begin
      if (!CLR) irq_q <= 4'h0;
      else      irq_q <= IRQ;
   end
`else
   assign pend_d = IRQ;
`endif

   always_ff @(negedge T3 or negedge CLR) begin
      if (!CLR) begin
         state_q <= S_IDLE;
         pend_q  <= 4'h0;
         mask_q  <= 4'hF;
         ie_q    <= 1'b0;
         ret_q   <= 8'h00;
         id_q    <= 2'd0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         mask_q  <= mask_d;
         ie_q    <= ie_d;
         ret_q   <= ret_d;
         id_q    <= id_d;
      end
   end

   logic       in_ack;
   logic       in_retn;
   logic [7:0] vec;

   assign in_ack  = (state_q == S_ACK);
   assign in_retn = (state_q == S_RETN);
   assign vec     = VEC_BASE + {4'b0000, id_q, 2'b00};

   assign cpu.TAKE    = in_ack | in_retn;
   assign cpu.LPC_OVR = in_ack | in_retn;
   assign cpu.BUS_OE  = in_ack | in_retn;
   assign cpu.BUS_OUT = in_ack  ? vec
                      : in_retn ? ret_q
                      : 8'h00;

   assign INT_ACK    = in_ack ? (4'b0001 << id_q) : 4'b0000;
   assign IE         = ie_q;
   assign PEND       = pend_q;
   assign IN_SERVICE = (state_q == S_SERVE);

endmodule

// File: tb/tb_int_sched.sv
// Randomized bench for int_sched against a phase-level reference model.
// Build with +define+INT_EDGE_EN to check the edge-triggered variant.
module tb_int_sched;

   localparam logic [7:0] VB = 8'hF0;
   localparam int P_IDLE = 0, P_ACK = 1, P_SERVE = 2, P_RETN = 3;

   logic       T3;
   logic       CLR;
   logic [3:0] IRQ;
   logic       MASK_WE;
   logic [3:0] MASK_D;
   logic       EI, DI;
   logic [3:0] INT_ACK;
   logic       IE;
   logic [3:0] PEND;
   logic       IN_SERVICE;

   int_sched_if cpu ();

   int_sched #(.VEC_BASE(VB)) dut (
      .T3(T3), .CLR(CLR), .IRQ(IRQ),
      .MASK_WE(MASK_WE), .MASK_D(MASK_D),
      .EI(EI), .DI(DI),
      .INT_ACK(INT_ACK), .IE(IE), .PEND(PEND),
      .IN_SERVICE(IN_SERVICE), .cpu(cpu)
   );

   initial T3 = 1'b1;
   always #5 T3 = ~T3;

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   // reference model: scheduler phase plus architectural registers
   int         m_phase;
   int         m_id;
   logic [3:0] m_pend, m_mask, m_prev;
   logic       m_ie;
   logic [7:0] m_ret;

   task automatic model_reset();
      m_phase = P_IDLE;
      m_id    = 0;
      m_pend  = 4'h0;
      m_mask  = 4'hF;
      m_prev  = 4'h0;
      m_ie    = 1'b0;
      m_ret   = 8'h00;
   endtask

   task automatic model_step();
      logic [3:0] elig;
      logic       acc;
      int         id;
      int         nphase;
      logic       nie;
      if (!CLR) begin
         model_reset();
         return;
      end
      elig = m_pend & ~m_mask;
      acc  = (m_phase == P_IDLE) && cpu.BOUNDARY && m_ie && (elig != 0);
      id   = m_id;
      if (acc)
         for (int i = 3; i >= 0; i--)
            if (elig[i]) id = i;
      nphase = m_phase;
      case (m_phase)
         P_IDLE:  if (acc) nphase = P_ACK;
         P_ACK:   nphase = P_SERVE;
         P_SERVE: if (cpu.IRET) nphase = P_RETN;
         default: nphase = P_IDLE;
      endcase
      nie = m_ie;
      if (m_phase == P_RETN) nie = 1'b1;
      if (EI)  nie = 1'b1;
      if (DI)  nie = 1'b0;
      if (acc) nie = 1'b0;
`ifdef INT_EDGE_EN
      if (acc) m_pend[id] = 1'b0;
      m_pend = m_pend | (IRQ & ~m_prev);
`else
      m_pend = IRQ;
`endif
      m_prev = IRQ;
      if (acc) m_ret = cpu.PC_IN;
      if (MASK_WE) m_mask = MASK_D;
      m_id    = id;
      m_ie    = nie;
      m_phase = nphase;
   endtask

   task automatic compare_all();
      logic       ovr;
      logic [7:0] bus;
      logic [3:0] ack;
      ovr = (m_phase == P_ACK) || (m_phase == P_RETN);
      bus = 8'h00;
      ack = 4'h0;
      if (m_phase == P_ACK) begin
         bus = 8'((int'(VB) + 4 * m_id) % 256);
         ack = 4'(1 << m_id);
      end
      if (m_phase == P_RETN) bus = m_ret;
      check("TAKE", cpu.TAKE, ovr);
      check("LPC_OVR", cpu.LPC_OVR, ovr);
      check("BUS_OE", cpu.BUS_OE, ovr);
      check("BUS_OUT", cpu.BUS_OUT, bus);
      check("INT_ACK", INT_ACK, ack);
      check("IE", IE, m_ie);
      check("PEND", PEND, m_pend);
      check("IN_SERVICE", IN_SERVICE, m_phase == P_SERVE);
   endtask

   task automatic step();
      @(negedge T3);
      model_step();
      #1;
      compare_all();
      @(posedge T3);
   endtask

   task automatic idle_inputs();
      MASK_WE = 0; EI = 0; DI = 0;
      cpu.BOUNDARY = 0; cpu.IRET = 0;
   endtask

   task automatic async_reset();
      #3;
      CLR = 1'b0;
      #1;
      model_reset();
      check("rst_take", cpu.TAKE, 1'b0);
      check("rst_bus", cpu.BUS_OUT, 8'h00);
      compare_all();
      step();
      CLR = 1'b1;
   endtask

   initial begin
      CLR = 0; IRQ = 0; MASK_D = 0; cpu.PC_IN = 0;
      idle_inputs();
      model_reset();
      repeat (2) @(posedge T3);
      compare_all();
      CLR = 1;

      // vector for id 2, then return to the saved PC
      EI = 1; step();
      EI = 0; MASK_WE = 1; MASK_D = 4'h0; step();
      MASK_WE = 0; IRQ = 4'b0100; step();
      cpu.BOUNDARY = 1; cpu.PC_IN = 8'h23; step();
      check("t1_take", cpu.TAKE, 1'b1);
      check("t1_vec", cpu.BUS_OUT, 8'hF8);
      check("t1_ack", INT_ACK, 4'b0100);
      check("t1_ie", IE, 1'b0);
      cpu.BOUNDARY = 0; step();
      cpu.IRET = 1; step();
      check("t2_take", cpu.TAKE, 1'b1);
      check("t2_ret", cpu.BUS_OUT, 8'h23);
      check("t2_lpc", cpu.LPC_OVR, 1'b1);
      cpu.IRET = 0; step();
      check("t2_ie", IE, 1'b1);
      check("t2_take_off", cpu.TAKE, 1'b0);

      // masked source 1 leaves source 3
      IRQ = 4'b1010; MASK_WE = 1; MASK_D = 4'b0010; step();
      MASK_WE = 0; cpu.BOUNDARY = 1; step();
      check("t3_vec", cpu.BUS_OUT, 8'hFC);
      check("t3_ack", INT_ACK, 4'b1000);
      cpu.BOUNDARY = 0; step();
      cpu.IRET = 1; step();
      cpu.IRET = 0; step();

      // DI beats EI; boundaries then never accept
      EI = 1; DI = 1; step();
      check("t4_ie", IE, 1'b0);
      EI = 0; DI = 0;
      for (int i = 0; i < 4; i++) begin
         cpu.BOUNDARY = 1; step();
         check("t4_take", cpu.TAKE, 1'b0);
         cpu.BOUNDARY = 0; step();
      end

      // reset while serving
      MASK_WE = 1; MASK_D = 4'h0; EI = 1; step();
      MASK_WE = 0; EI = 0; cpu.BOUNDARY = 1; step();
      cpu.BOUNDARY = 0; step();
      check("t5_serve", IN_SERVICE, 1'b1);
      async_reset();
      IRQ = 4'hF;
      for (int i = 0; i < 4; i++) begin
         cpu.BOUNDARY = 1; step();
         check("t5_take", cpu.TAKE, 1'b0);
      end
      cpu.BOUNDARY = 0;

      // one-cycle pulse on IRQ[0] while interrupts are off
      async_reset();
      IRQ = 4'h0; MASK_WE = 1; MASK_D = 4'h0; step();
      MASK_WE = 0; IRQ = 4'b0001; step();
      IRQ = 4'h0; step();
      EI = 1; step();
      EI = 0; cpu.BOUNDARY = 1; step();
`ifdef INT_EDGE_EN
      check("t6_take", cpu.TAKE, 1'b1);
      check("t6_vec", cpu.BUS_OUT, 8'hF0);
`else
      check("t6_take", cpu.TAKE, 1'b0);
`endif
      idle_inputs();

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 3) == 0) IRQ = 4'($urandom);
         MASK_WE      = ($urandom_range(0, 7) == 0);
         MASK_D       = 4'($urandom) & 4'($urandom);
         EI           = ($urandom_range(0, 5) == 0);
         DI           = ($urandom_range(0, 11) == 0);
         cpu.BOUNDARY = ($urandom_range(0, 2) == 0);
         cpu.IRET     = ($urandom_range(0, 4) == 0);
         cpu.PC_IN    = 8'($urandom);
         if ($urandom_range(0, 199) == 0) async_reset();
         else step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
